// File: rtl/controller_multiplier.sv
// controller_multiplier: IDLE/RUN/DONE controller sequencing a shift-add multiplier datapath
module controller_multiplier #(
  parameter int N = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     b0,
  input  logic                     z,
  output logic [1:2]               en,
  output logic [1:3]               load,
  output logic                     s,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N+1)-1:0]   iter
);
  localparam int W = $clog2(N+1);
  localparam logic [W-1:0] LAST = W'(N);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]   r_state, w_next;
  logic [W-1:0] r_iter;
  logic         w_accept, w_step;
  always_comb begin
    w_accept  = r_state == IDLE && in_valid;
    w_step    = r_state == RUN && !z && r_iter != LAST;
    w_next    = w_accept ? RUN :
                r_state == RUN && !w_step ? DONE :
                r_state == DONE && out_ready ? IDLE :
                r_state == 2'd3 ? IDLE : r_state;
    in_ready  = !reset && r_state == IDLE;
    out_valid = !reset && r_state == DONE;
    en        = (!reset && w_step) ? 2'b11 : 2'b00;
    load      = reset ? 3'b000 : w_accept ? 3'b111 : {2'b00, w_step && b0};
    s         = !reset && w_step;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      r_iter  <= w_accept ? '0 : w_step ? r_iter + 1'b1 : r_iter;
    end
  end
  assign iter = r_iter;
endmodule

// File: tb/tb_controller_multiplier.sv
// tb_controller_multiplier: directed vectors against a behavioural shift-add datapath
module tb_controller_multiplier;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          it;
    int          lat;
    int          hold;
    bit          poke;
  } vec_t;

  logic       clock = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic       in_ready, s, out_valid, b0, z;
  logic [1:2] en;
  logic [1:3] load;
  logic [3:0] iter;
  logic [7:0] in_a = 0, in_b = 0, dp_b = 0;
  logic [15:0] dp_a = 0, dp_p = 0;
  int total = 0, bad = 0;
  vec_t v[7];

  controller_multiplier #(.N(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .b0(b0), .z(z), .en(en), .load(load), .s(s), .out_valid(out_valid),
    .out_ready(out_ready), .iter(iter)
  );

  always #5 clock = ~clock;

  assign b0 = dp_b[0];
  assign z  = dp_b == 8'd0;

  always @(posedge clock) begin
    if (load[1]) dp_b <= in_b; else if (en[1]) dp_b <= dp_b >> 1;
    if (load[2]) dp_a <= {8'd0, in_a}; else if (en[2]) dp_a <= dp_a << 1;
    if (load[3]) dp_p <= s ? dp_p + dp_a : 16'd0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t t);
    int lat = 0;
    int steps = 0;
    bit leak = 0;
    in_a = t.a; in_b = t.b; in_valid = 1; out_ready = 0;
    #1;
    chk("accept_ready", in_ready, 1);
    chk("accept_load", load, 3'b111);
    chk("accept_s", s, 0);
    chk("accept_en", en, 0);
    @(negedge clock);
    in_valid = t.poke; in_a = 8'hAA; in_b = 8'h55;
    #1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (en == 2'b11) steps++;
      if (load[1] || load[2]) leak = 1;
      @(negedge clock); #1;
      lat++;
    end
    chk("out_valid", out_valid, 1);
    chk("latency", lat, t.lat);
    chk("product", dp_p, t.p);
    chk("iter", iter, t.it);
    chk("steps", steps, t.it);
    chk("busy_no_load", leak, 0);
    chk("done_ready", in_ready, 0);
    chk("done_load", load, 0);
    chk("done_en", en, 0);
    repeat (t.hold) begin
      @(negedge clock); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_p", dp_p, t.p);
      chk("hold_ready", in_ready, 0);
      chk("hold_load", load, 0);
    end
    out_ready = 1; in_valid = 0;
    @(negedge clock); #1;
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
    chk("iter_kept", iter, t.it);
    chk("idle_p", dp_p, t.p);
    out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = '{8'd5,   8'd3,   16'd15,    2, 4,  0, 1'b0};
    v[1] = '{8'd200, 8'd0,   16'd0,     0, 2,  0, 1'b0};
    v[2] = '{8'd255, 8'd255, 16'd65025, 8, 10, 0, 1'b0};
    v[3] = '{8'd7,   8'd9,   16'd63,    4, 6,  3, 1'b0};
    v[4] = '{8'd1,   8'd128, 16'd128,   8, 10, 0, 1'b1};
    v[5] = '{8'd13,  8'd6,   16'd78,    3, 5,  1, 1'b1};
    v[6] = '{8'd0,   8'd77,  16'd0,     7, 9,  0, 1'b0};
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_load", load, 0);
    chk("rst_iter", iter, 0);
    reset = 0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    for (int i = 0; i < 7; i++) do_op(v[i]);
    in_a = 8'd255; in_b = 8'd255; in_valid = 1;
    @(negedge clock);
    in_valid = 0;
    @(negedge clock);
    @(negedge clock); #1;
    chk("mid_run_en", en, 2'b11);
    reset = 1;
    #1;
    chk("mid_rst_en", en, 0);
    chk("mid_rst_load", load, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    @(negedge clock);
    reset = 0;
    #1;
    chk("after_rst_ready", in_ready, 1);
    chk("after_rst_iter", iter, 0);
    chk("after_rst_en", en, 0);
    chk("after_rst_valid", out_valid, 0);
    do_op('{8'd2, 8'd2, 16'd4, 2, 4, 0, 1'b0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
